// File: rtl/rand_dispatch_pkg.sv
// Shared types and constants for the random-number dispatcher.
// The LFSR tap mask selects bits 15,14,12,3 (taps 16,15,13,4).
package rand_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DELIVER
    } state_e;

    localparam logic [15:0] LFSR_TAPS     = 16'hD008;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam logic [15:0] LFSR_ZERO_ESC = 16'h0001;

endpackage

// File: rtl/rand_dispatch_if.sv
// Requester-side bundle: level requests in, one-hot ack and value out.
interface rand_dispatch_if #(
    parameter int N_REQ     = 4,
    parameter int SIZE_BITS = 11
);

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     ack;
    logic [SIZE_BITS-1:0] dout;
    logic                 busy;

    modport master (output req, input ack, dout, busy);
    modport slave  (input req, output ack, dout, busy);

endinterface

// File: rtl/rand_dispatch_lfsr16.sv
// 16-bit Fibonacci LFSR with a free-running counter that is folded in
// on each rising edge of seed_rise.
module lfsr16
    import rand_dispatch_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_rise,
    output logic [15:0] lfsr_q
);

    logic [15:0] lfsr_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] mixed;
    logic        seed_q;
    logic        seed_d;

    always_comb begin
        cnt_d  = cnt_q + 16'd1;
        seed_d = seed_rise;
        mixed  = lfsr_q ^ cnt_q;
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        // An all-zero state would lock the LFSR, so escape to 1.
        if (seed_rise && !seed_q) begin
            lfsr_d = (mixed == 16'h0) ? LFSR_ZERO_ESC : mixed;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
            cnt_q  <= 16'h0;
            seed_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            seed_q <= seed_d;
        end
    end

endmodule

// File: rtl/rand_dispatch.sv
// Round-robin dispatcher handing out range-limited LFSR values
// drawn by rejection sampling, with a midpoint fallback.
module rand_dispatch
    import rand_dispatch_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter int          SIZE_BITS = 11,
    parameter int          MIN_VAL   = 0,
    parameter int          MAX_VAL   = 255,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_rise,
    rand_dispatch_if.slave   bus
);

    localparam int SPAN  = MAX_VAL - MIN_VAL;
    localparam int MBITS = (SPAN < 1) ? 1 : $clog2(SPAN + 1);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);

    localparam logic [SIZE_BITS-1:0] FALLBACK = SIZE_BITS'((MAX_VAL + MIN_VAL) / 2);
    localparam logic [SIZE_BITS-1:0] MIN_V    = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] SPAN_V   = SIZE_BITS'(SPAN);
    localparam logic [TRY_W-1:0]     LAST_TRY = TRY_W'(MAX_TRIES - 1);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [SIZE_BITS-1:0] dout_q, dout_d;
    logic [15:0]          lfsr_q;
    logic [SIZE_BITS-1:0] cand;
    logic [PTR_W-1:0]     pick;
    logic                 found;
    logic                 lfsr_unused;
    int                   idx;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_rise (seed_rise),
        .lfsr_q    (lfsr_q)
    );

    assign cand        = SIZE_BITS'(lfsr_q[MBITS-1:0]);
    assign lfsr_unused = ^lfsr_q;

    // First pending requester at or after rr_q, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_q) + i) % N_REQ;
            if (!found && bus.req[PTR_W'(idx)]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        tries_d = tries_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!bus.req[grant_q]) begin
                    state_d = IDLE;
                end else if (cand <= SPAN_V) begin
                    dout_d  = cand + MIN_V;
                    state_d = DELIVER;
                end else if (tries_q == LAST_TRY) begin
                    dout_d  = FALLBACK;
                    state_d = DELIVER;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            DELIVER: begin
                rr_d    = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack = '0;
        if (state_q == DELIVER) bus.ack[grant_q] = 1'b1;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.dout = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            tries_q <= '0;
            dout_q  <= FALLBACK;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tries_q <= tries_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_rand_dispatch.sv
// Bench for rand_dispatch: three instances (default range, 10..20,
// and 10..20 with two tries and a seed that exercises the zero escape).
module tb_rand_dispatch;

    localparam int N  = 4;
    localparam int SB = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] seed;

    always #5 clk = ~clk;

    rand_dispatch_if #(.N_REQ(N), .SIZE_BITS(SB)) bus_a ();
    rand_dispatch_if #(.N_REQ(N), .SIZE_BITS(SB)) bus_b ();
    rand_dispatch_if #(.N_REQ(N), .SIZE_BITS(SB)) bus_c ();

    rand_dispatch #(.N_REQ(N), .SIZE_BITS(SB)) dut_a (
        .clk(clk), .reset(reset), .seed_rise(seed[0]), .bus(bus_a)
    );
    rand_dispatch #(.N_REQ(N), .SIZE_BITS(SB), .MIN_VAL(10), .MAX_VAL(20)) dut_b (
        .clk(clk), .reset(reset), .seed_rise(seed[1]), .bus(bus_b)
    );
    rand_dispatch #(.N_REQ(N), .SIZE_BITS(SB), .MIN_VAL(10), .MAX_VAL(20),
                    .MAX_TRIES(2), .LFSR_SEED(16'h8000)) dut_c (
        .clk(clk), .reset(reset), .seed_rise(seed[2]), .bus(bus_c)
    );

    typedef struct {
        logic [15:0] lfsr;
        logic [15:0] cnt;
        bit          sprev;
        bit          active;
        bit          deliver;
        int          grant;
        int          tries;
        int          rr;
        int          dout;
    } model_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    int          lo[3] = '{0, 10, 10};
    int          hi[3] = '{255, 20, 20};
    int          mt[3] = '{8, 8, 2};
    logic [15:0] sd[3] = '{16'hACE1, 16'hACE1, 16'h8000};

    model_t m[3];
    int     vecs = 0;
    int     errs = 0;

    function automatic logic [15:0] lfsr_adv(logic [15:0] v);
        int taps[4] = '{16, 15, 13, 4};
        bit fb = 1'b0;
        foreach (taps[k]) fb ^= v[taps[k] - 1];
        return {v[14:0], fb};
    endfunction

    function automatic int mbits(int span);
        int b = 1;
        while ((1 << b) <= span) b++;
        return b;
    endfunction

    function automatic model_t m_reset(int k);
        model_t n;
        n.lfsr = sd[k]; n.cnt = 16'h0; n.sprev = 1'b0;
        n.active = 1'b0; n.deliver = 1'b0;
        n.grant = 0; n.tries = 0; n.rr = 0;
        n.dout = (lo[k] + hi[k]) / 2;
        return n;
    endfunction

    // One clock of the reference behaviour, given inputs seen at that edge.
    function automatic model_t m_step(model_t x, int k, logic [3:0] r, bit s, bit rst);
        model_t n = x;
        int span = hi[k] - lo[k];
        int cand;
        if (rst) return m_reset(k);
        n.cnt = x.cnt + 16'd1;
        n.sprev = s;
        if (s && !x.sprev)
            n.lfsr = ((x.lfsr ^ x.cnt) == 16'h0) ? 16'h0001 : (x.lfsr ^ x.cnt);
        else
            n.lfsr = lfsr_adv(x.lfsr);
        n.deliver = 1'b0;
        if (x.deliver) begin
            n.active = 1'b0;
            n.rr = (x.grant + 1) % N;
        end else if (!x.active) begin
            for (int i = 0; i < N; i++) begin
                if (r[(x.rr + i) % N]) begin
                    n.grant = (x.rr + i) % N;
                    n.active = 1'b1;
                    n.tries = 0;
                    break;
                end
            end
        end else if (!r[x.grant]) begin
            n.active = 1'b0;
        end else begin
            cand = int'(x.lfsr) % (1 << mbits(span));
            if (cand <= span) begin
                n.dout = cand + lo[k];
                n.deliver = 1'b1;
            end else if (x.tries + 1 == mt[k]) begin
                n.dout = (lo[k] + hi[k]) / 2;
                n.deliver = 1'b1;
            end else begin
                n.tries = x.tries + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_ack(model_t x);
        return x.deliver ? 4'(1 << x.grant) : 4'b0;
    endfunction

    function automatic logic [15:0] exp_out(model_t x);
        return {exp_ack(x), x.active, SB'(x.dout)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(logic [3:0] ra, logic [3:0] rb, logic [3:0] rc,
                        logic [2:0] s, bit rst);
        bus_a.req = ra; bus_b.req = rb; bus_c.req = rc;
        seed = s; reset = rst;
        @(posedge clk);
        m[0] = m_step(m[0], 0, ra, s[0], rst);
        m[1] = m_step(m[1], 1, rb, s[1], rst);
        m[2] = m_step(m[2], 2, rc, s[2], rst);
        @(negedge clk);
        chk("a.out", {bus_a.ack, bus_a.busy, bus_a.dout}, exp_out(m[0]));
        chk("b.out", {bus_b.ack, bus_b.busy, bus_b.dout}, exp_out(m[1]));
        chk("c.out", {bus_c.ack, bus_c.busy, bus_c.dout}, exp_out(m[2]));
        chk("a.lfsr", dut_a.lfsr_q, m[0].lfsr);
        chk("c.lfsr", dut_c.lfsr_q, m[2].lfsr);
    endtask

    function automatic logic [3:0] nreq(logic [3:0] r, logic [3:0] a);
        logic [3:0] n = r;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                if (a[i] && $urandom_range(1, 0) == 0) n[i] = 1'b0;
                else if ($urandom_range(63, 0) == 0) n[i] = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
                n[i] = 1'b1;
            end
        end
        return n;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [3:0] ra, rb, rc;
        logic [2:0] s;
        bit         got;
        bit         bad;
        int         nack;
        int         t;

        for (int k = 0; k < 3; k++) m[k] = m_reset(k);
        for (int g = 0; g < 12; g++) begin
            tbl.push_back('{4'b1111, 4'b0000, 1'b1});
            tbl.push_back('{4'b1111, 4'(1 << (g % 4)), 1'b1});
            tbl.push_back('{4'b1111, 4'b0000, 1'b0});
        end
        tbl.push_back('{4'b0001, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 4'b0001, 1'b1});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0});

        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("rst.ack", bus_a.ack, 4'b0);
        chk("rst.busy", bus_a.busy, 1'b0);
        chk("rst.dout_a", bus_a.dout, 11'd127);
        chk("rst.dout_b", bus_b.dout, 11'd15);
        chk("rst.lfsr_a", dut_a.lfsr_q, 16'hACE1);
        chk("rst.lfsr_c", dut_c.lfsr_q, 16'h8000);

        // Rounds of 1111 then a lone 0001; dut_c reseeds into a zero result.
        foreach (tbl[i]) begin
            tick(tbl[i].req, 0, 0, (i == 1) ? 3'b100 : 3'b000, 0);
            chk("tbl.ack", bus_a.ack, tbl[i].ack);
            chk("tbl.busy", bus_a.busy, tbl[i].busy);
            if (i == 1) chk("zero_escape", dut_c.lfsr_q, 16'h0001);
        end

        tick(4'b0001, 0, 0, 0, 0);
        chk("pre_rst.busy", bus_a.busy, 1'b1);
        tick(4'b0001, 0, 0, 0, 1);
        chk("mid_rst.ack", bus_a.ack, 4'b0);
        chk("mid_rst.busy", bus_a.busy, 1'b0);
        chk("mid_rst.dout", bus_a.dout, 11'd127);
        chk("mid_rst.lfsr", dut_a.lfsr_q, 16'hACE1);

        for (int i = 0; i < 50; i++) tick(4'b0001, 4'b1111, 0, 3'b011, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        // Abort on dut_b: serve 1, abandon a draw for 2, then 2 must win.
        got = 1'b0;
        for (t = 0; t < 40 && !got; t++) begin
            tick(0, 4'b0010, 0, 0, 0);
            if (bus_b.ack != 4'b0) got = 1'b1;
        end
        chk("b.serve1", got ? bus_b.ack : 4'b0, 4'b0010);
        tick(0, 0, 0, 0, 0);
        t = 0;
        while (!(!m[1].active && (int'(lfsr_adv(m[1].lfsr)) % 16) > 10) && t < 200) begin
            tick(0, 0, 0, 0, 0);
            t++;
        end
        chk("b.find_reject", t < 200, 1'b1);
        bad = 1'b0;
        tick(0, 4'b0100, 0, 0, 0);
        bad |= (bus_b.ack != 4'b0);
        tick(0, 4'b0100, 0, 0, 0);
        bad |= (bus_b.ack != 4'b0);
        chk("b.redraw_busy", bus_b.busy, 1'b1);
        tick(0, 4'b0000, 0, 0, 0);
        bad |= (bus_b.ack != 4'b0);
        chk("b.abort_noack", bad, 1'b0);
        chk("b.abort_idle", bus_b.busy, 1'b0);
        got = 1'b0;
        for (t = 0; t < 40 && !got; t++) begin
            tick(0, 4'b0101, 0, 0, 0);
            if (bus_b.ack != 4'b0) got = 1'b1;
        end
        chk("b.after_abort", got ? bus_b.ack : 4'b0, 4'b0100);
        tick(0, 0, 0, 0, 0);

        ra = 0; rb = 0; rc = 0; nack = 0;
        for (t = 0; t < 30000 && nack < 1000; t++) begin
            ra = nreq(ra, bus_a.ack);
            rb = nreq(rb, bus_b.ack);
            rc = nreq(rc, bus_c.ack);
            s = {$urandom_range(49, 0) == 0, $urandom_range(49, 0) == 0,
                 $urandom_range(49, 0) == 0};
            tick(ra, rb, rc, s, 0);
            if (bus_b.ack != 4'b0) begin
                nack++;
                chk("b.range", bus_b.dout >= 11'd10 && bus_b.dout <= 11'd20, 1'b1);
            end
            if (bus_c.ack != 4'b0)
                chk("c.range", bus_c.dout >= 11'd10 && bus_c.dout <= 11'd20, 1'b1);
        end
        chk("b.ack_count", nack, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rand_dispatch.md
# rand_dispatch

Shares one on-chip pseudo-random source among N_REQ requesters, such as ghost direction logic or bonus-item placement, using a req/ack handshake with round-robin fairness. Each delivered value lies in [MIN_VAL, MAX_VAL], produced by rejection sampling of a 16-bit LFSR. A key-press rising edge folds a free-running counter into the LFSR so that game sessions diverge. The block sits between the game-logic requesters and the keyboard front end.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- SIZE_BITS, 11, width of dout
- MIN_VAL, 0, smallest deliverable value
- MAX_VAL, 255, largest deliverable value (MAX_VAL ≥ MIN_VAL, MAX_VAL < 2^SIZE_BITS)
- MAX_TRIES, 8, rejected draws before fallback
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- seed_rise  in  1  reseed strobe (key pressed); edge-detected internally
- req  in  N_REQ  per-requester request, level, held until ack
- ack  out  N_REQ  one-hot, one-cycle pulse; dout is valid in the same cycle
- dout  out  SIZE_BITS  last delivered value, held until next delivery
- busy  out  1  high in DRAW and DELIVER

## Operation
- Range constants: SPAN = MAX_VAL−MIN_VAL; MBITS = $clog2(SPAN+1), minimum 1.
- LFSR is 16-bit Fibonacci, taps 16,15,13,4, shifting every cycle regardless of state.
- A 16-bit free-running counter runs alongside the LFSR.
- Candidate value = lfsr[MBITS-1:0], zero-extended.
- Reseed: on a rising edge of seed_rise (seed_rise=1 with the previous cycle's value 0):
  - lfsr ← lfsr XOR counter;
  - if the result is zero, lfsr ← 16'h0001.
  - The reseed replaces that cycle's shift.
- FSM states: IDLE, DRAW, DELIVER.
- IDLE:
  - If req is nonzero, grant the first set bit at or after rr_ptr, cyclically.
  - Latch the grant, clear tries, go to DRAW.
- DRAW, one candidate per cycle:
  - If req[grant]=0, abort to IDLE. No ack is issued and rr_ptr is unchanged.
  - Else if candidate ≤ SPAN: dout ← candidate+MIN_VAL, go to DELIVER.
  - Else if tries = MAX_TRIES−1: dout ← (MAX_VAL+MIN_VAL)/2 (fallback), go to DELIVER.
  - Else tries++ and stay in DRAW.
- DELIVER:
  - ack[grant]=1 for this cycle only.
  - rr_ptr ← (grant+1) mod N_REQ.
  - Go to IDLE.
- A requester that keeps req high after its ack is treated as a new request. It is not re-served until the other pending requesters have each been served once.
- Arithmetic: candidate+MIN_VAL is computed at SIZE_BITS width; the parameter constraints rule out overflow.

## Timing
- Reset values: ack=0, dout=(MAX_VAL+MIN_VAL)/2, busy=0, state=IDLE, rr_ptr=0, lfsr=LFSR_SEED, counter=0, seed edge register=0.
- Reset in any state returns to these values on the next clock edge; any in-flight grant is discarded without ack.
- Latency, req sampled high in IDLE at cycle t:
  - DRAW at t+1;
  - with first-candidate acceptance, ack and the new dout appear at t+2.
  - Worst case: ack at t+1+MAX_TRIES.
- Service rate: at most one ack per 3 cycles.
- dout changes only on the cycle ack is asserted, or at reset.
- A seed_rise edge during DRAW only alters later candidates; the draw in progress continues.

## Structure
- Package rand_dispatch_pkg:
  - state enum {IDLE, DRAW, DELIVER};
  - LFSR tap constant;
  - default seed;
  - the 16'h0001 zero-escape constant.
- Sub-module lfsr16 owns the LFSR, the free-running counter and the reseed edge detector.
  - Ports: clk, reset, seed_rise, lfsr_q.
- The top level holds the FSM, the round-robin pointer, the tries counter and the dout register.

## Test plan
- Default parameters, req=4'b0001 held → ack=4'b0001 exactly two cycles after req is sampled; dout in 0..255; busy high for 2 cycles.
- req=4'b1111 held for 12 acks → ack order 0,1,2,3,0,1,2,3,0,1,2,3 with no repeats out of turn.
- MIN_VAL=10, MAX_VAL=20, 1000 requests → every dout in 10..20. When the model LFSR gives MAX_TRIES rejections in a row, dout=15 at ack t+9.
- req[2] raised, then dropped during DRAW (MIN=10, MAX=20, with a rejection forced by the seed) → no ack; rr_ptr unchanged; next req[2] is served first.
- Assert reset during DRAW → next cycle: ack=0, busy=0, dout=127 (default parameters); lfsr=16'hACE1.
- seed_rise held high for 50 cycles → exactly one reseed, matching the model (lfsr XOR counter at the edge cycle). A forced zero result loads 16'h0001.
